// File: rtl/sram_port_arbiter.sv
// Arbitrates one single-ported synchronous SRAM between the instruction-fetch
// port and the data (load/store) port. MEM normally wins a conflict; a wait
// counter forces IF through after MAX_WAIT consecutive denied cycles. Read
// data returns one cycle after the grant and is steered by a registered owner
// state; each port keeps its last read word for stalled consumers.
module sram_port_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                inst_req,
  input  logic [ADDR_W-1:0]   inst_addr,
  output logic                inst_gnt,
  output logic                inst_rvalid,
  output logic [DATA_W-1:0]   inst_rdata,
  input  logic                data_req,
  input  logic [DATA_W/8-1:0] data_wen,
  input  logic [ADDR_W-1:0]   data_addr,
  input  logic [DATA_W-1:0]   data_wdata,
  output logic                data_gnt,
  output logic                data_rvalid,
  output logic [DATA_W-1:0]   data_rdata,
  output logic                sram_en,
  output logic [DATA_W/8-1:0] sram_wen,
  output logic [ADDR_W-1:0]   sram_addr,
  output logic [DATA_W-1:0]   sram_wdata,
  input  logic [DATA_W-1:0]   sram_rdata,
  output logic                stallreq_if,
  output logic                stallreq_mem
);

  localparam logic [3:0] WAIT_LIMIT = 4'(MAX_WAIT);

  typedef enum logic [1:0] {
    RESP_NONE = 2'd0,
    RESP_INST = 2'd1,
    RESP_DATA = 2'd2
  } resp_state_t;

  resp_state_t       resp_state_q, resp_state_d;
  logic [3:0]        wait_cnt_q, wait_cnt_d;
  logic [DATA_W-1:0] inst_hold_q, inst_hold_d;
  logic [DATA_W-1:0] data_hold_q, data_hold_d;
  logic              starve;

  assign starve = (wait_cnt_q == WAIT_LIMIT);

  // Same-cycle grant: MEM has priority unless IF has waited MAX_WAIT cycles.
  always_comb begin
    inst_gnt = 1'b0;
    data_gnt = 1'b0;
    if (inst_req && data_req) begin
      if (starve) inst_gnt = 1'b1;
      else        data_gnt = 1'b1;
    end else if (inst_req) begin
      inst_gnt = 1'b1;
    end else if (data_req) begin
      data_gnt = 1'b1;
    end
  end

  // SRAM command mux; an IF access is always a read, idle drives zeros.
  always_comb begin
    sram_en    = inst_gnt | data_gnt;
    sram_wen   = '0;
    sram_addr  = '0;
    sram_wdata = '0;
    if (data_gnt) begin
      sram_wen   = data_wen;
      sram_addr  = data_addr;
      sram_wdata = data_wdata;
    end else if (inst_gnt) begin
      sram_addr  = inst_addr;
    end
  end

  assign stallreq_if  = inst_req & ~inst_gnt;
  assign stallreq_mem = data_req & ~data_gnt;

  // Count consecutive denied IF cycles, saturating at the forcing threshold.
  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (!inst_req || inst_gnt) begin
      wait_cnt_d = 4'd0;
    end else if (wait_cnt_q != WAIT_LIMIT) begin
      wait_cnt_d = wait_cnt_q + 4'd1;
    end
  end

  // Record which port owns the read issued this cycle; writes return nothing.
  always_comb begin
    resp_state_d = RESP_NONE;
    if (inst_gnt) begin
      resp_state_d = RESP_INST;
    end else if (data_gnt && (data_wen == '0)) begin
      resp_state_d = RESP_DATA;
    end
  end

  assign inst_rvalid = (resp_state_q == RESP_INST);
  assign data_rvalid = (resp_state_q == RESP_DATA);
  assign inst_rdata  = inst_rvalid ? sram_rdata : inst_hold_q;
  assign data_rdata  = data_rvalid ? sram_rdata : data_hold_q;

  // Capture the returning word at the end of each port's valid cycle.
  always_comb begin
    inst_hold_d = inst_rvalid ? sram_rdata : inst_hold_q;
    data_hold_d = data_rvalid ? sram_rdata : data_hold_q;
  end

  // State registers; reset discards any outstanding read immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      resp_state_q <= RESP_NONE;
      wait_cnt_q   <= 4'd0;
      inst_hold_q  <= '0;
      data_hold_q  <= '0;
    end else begin
      resp_state_q <= resp_state_d;
      wait_cnt_q   <= wait_cnt_d;
      inst_hold_q  <= inst_hold_d;
      data_hold_q  <= data_hold_d;
    end
  end

endmodule

// File: doc/sram_port_arbiter.md
Name: sram_port_arbiter

Overview:
- Shares one single-ported synchronous SRAM between the instruction-fetch requester (IF) and the data requester (MEM load/store).
- Grants one requester per cycle and routes the read response, which arrives one cycle later, back to its owner.
- Holds each port's last read data for stalled stages.
- Raises stall requests toward the pipeline stall controller.
- A bounded-wait counter stops IF from being starved by back-to-back MEM accesses.

Parameters:
- ADDR_W, 32, address width of both requesters and the SRAM.
- DATA_W, 32, data width; byte-enable width is DATA_W/8.
- MAX_WAIT, 4, consecutive cycles IF may be denied before it is forced to win; legal range 1..15.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- inst_req  in  1  IF read request.
- inst_addr  in  ADDR_W  IF address.
- inst_gnt  out  1  IF granted this cycle.
- inst_rvalid  out  1  IF read data valid (one-cycle pulse).
- inst_rdata  out  DATA_W  IF read data (bypass or held).
- data_req  in  1  MEM request.
- data_wen  in  DATA_W/8  MEM byte write enables; 0 = read.
- data_addr  in  ADDR_W  MEM address.
- data_wdata  in  DATA_W  MEM write data.
- data_gnt  out  1  MEM granted this cycle.
- data_rvalid  out  1  MEM read data valid (one-cycle pulse, reads only).
- data_rdata  out  DATA_W  MEM read data (bypass or held).
- sram_en  out  1  SRAM enable.
- sram_wen  out  DATA_W/8  SRAM byte write enables.
- sram_addr  out  ADDR_W  SRAM address.
- sram_wdata  out  DATA_W  SRAM write data.
- sram_rdata  in  DATA_W  SRAM read data; valid the cycle after an enabled read.
- stallreq_if  out  1  IF request not granted this cycle.
- stallreq_mem  out  1  MEM request not granted this cycle.

Behaviour:
- Grant (combinational, same cycle):
  - Only one req high: that requester is granted.
  - Both high: MEM wins, unless starve = (wait_cnt == MAX_WAIT), in which case IF wins.
  - Neither high: no grant.
- SRAM drive:
  - sram_en = inst_gnt | data_gnt.
  - On data_gnt: sram_wen/addr/wdata = data_wen/data_addr/data_wdata.
  - On inst_gnt: sram_wen = 0, sram_addr = inst_addr, sram_wdata = 0.
  - No grant: all SRAM outputs 0.
- Stall outputs: stallreq_if = inst_req & ~inst_gnt; stallreq_mem = data_req & ~data_gnt.
- wait_cnt (width 4):
  - Cleared when inst_gnt or ~inst_req.
  - Incremented when inst_req & ~inst_gnt.
  - Saturates at MAX_WAIT.
- Response FSM (registered owner of the outstanding read), states RESP_NONE, RESP_INST, RESP_DATA:
  - Next state = RESP_INST if inst_gnt.
  - Next state = RESP_DATA if data_gnt & (data_wen == 0).
  - Otherwise RESP_NONE. Writes never produce a response.
  - Transitions occur every cycle; back-to-back grants pipeline with no bubble.
- Outputs by state:
  - inst_rvalid = (state == RESP_INST); data_rvalid = (state == RESP_DATA).
  - inst_rdata = inst_rvalid ? sram_rdata : inst_hold.
  - data_rdata = data_rvalid ? sram_rdata : data_hold.
  - Each hold register loads sram_rdata on the clock edge ending its rvalid cycle. It keeps that value until the next rvalid for the same port.
- Latency: grant in cycle N, rdata valid in cycle N+1. A write is complete at the end of cycle N.
- Simultaneous IF response and new MEM grant in the same cycle is legal: the response is routed by the registered state, and the grant is independent of it.
- Reset (asynchronous):
  - State = RESP_NONE, wait_cnt = 0, hold registers = 0.
  - All registered outputs drop immediately: rvalid = 0, rdata = 0.
  - Any read outstanding at reset is discarded; no rvalid is produced after reset release.
  - Combinational grant and SRAM outputs follow inputs; the bench holds req low during reset.

Test Plan:
- IF only, inst_addr=0x100, SRAM returns 0xDEADBEEF next cycle -> inst_gnt=1 and sram_addr=0x100 in cycle 0; inst_rvalid=1 and inst_rdata=0xDEADBEEF in cycle 1; inst_rdata stays 0xDEADBEEF in cycle 2 with inst_rvalid=0.
- Both requesting continuously, MAX_WAIT=4 -> data_gnt in cycles 0-3 with stallreq_if=1; inst_gnt and stallreq_mem=1 in cycle 4; data_gnt again in cycles 5-8.
- MEM store, data_wen=4'b0011, addr=0x200, wdata=0x0000ABCD -> sram_wen=0011, sram_wdata=0x0000ABCD in cycle 0; data_rvalid=0 in cycle 1.
- Alternating IF read (cycle 0) then MEM read (cycle 1), SRAM returns 0x11111111 then 0x22222222 -> inst_rvalid with 0x11111111 in cycle 1; data_rvalid with 0x22222222 in cycle 2; no cross-routing.
- rst asserted mid-cycle after an IF grant -> inst_rvalid/inst_rdata go 0 without waiting for clk; after release, no rvalid until a new grant.
- No requests for 3 cycles -> sram_en=0, sram_wen=0, stall outputs 0, wait_cnt stays 0.
